me_sad_search: RTL and testbench
================================

// Module: me_sad_search
// PURPOSE
//  Full-search integer motion estimator that sits directly downstream of the
//  22x22 search-window register file. It steps R_ROW/R_COL over all 7x7
//  candidate codes and computes a 16x16 SAD against the current block for
//  each one. It reports the minimum SAD and its code/displacement to the
//  mode-decision stage.
// PARAMETERS
//  PIX_W  8   pixel width in bits
//  BLK    16  block dimension (pixels per column, columns per block)
//  SAD_W  16  SAD width; must hold BLK*BLK*(2^PIX_W-1) = 65280
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     synchronous, active-high
//  start      in   1     request a search; sampled only in IDLE
//  cur_block  in   2048  current block; pixel(col c,row r) = [2047-(c*128+r*8) -: 8]
//  cand_block in   2048  candidate from window regfile DataOUT, same packing
//  R_ROW      out  3     row position code to window regfile
//  R_COL      out  3     column position code to window regfile
//  busy       out  1     high from cycle after start accepted until done cycle incl.
//  done       out  1     one-cycle pulse; results valid from this cycle
//  best_sad   out  16    minimum SAD
//  best_row   out  3     R_ROW code of minimum
//  best_col   out  3     R_COL code of minimum
//  mv_y/mv_x  out  3     signed displacement: code 0..6 -> 0,+1,+2,+3,-1,-2,-3
// BEHAVIOUR
//  - Reset: FSM=IDLE, all outputs 0, pipeline valid bits cleared. Applies mid-scan.
//  - States: IDLE -> SCAN (49 cyc) -> DRAIN (2 cyc) -> DONE (1 cyc) -> IDLE.
//  - IDLE: R_ROW=R_COL=0; start=1 accepted, best register preset to 16'hFFFF.
//  - SCAN: issue one position per cycle; R_COL outer 0..6, R_ROW inner 0..6
//    (first issue (0,0)=centre, last (6,6)). cand_block is combinational from
//    the regfile, so it is consumed in the issue cycle.
//  - Pipe S1: 16 per-column SADs (12 b each) + valid + codes registered at end
//    of issue cycle. S2: sum to 16 b, registered next edge. S3: if valid and
//    sad < best (strict), update best_sad/row/col on next edge.
//  - Ties keep the earliest in scan order (centre preferred).
//  - Timing: start sampled in cycle 0; SCAN cycles 1..49; DRAIN 50..51;
//    done=1 in cycle 52; busy=1 in cycles 1..52.
//  - start while not IDLE is ignored. start held high in the DONE cycle is
//    ignored; it is accepted in the following IDLE cycle.
//  - best_* / mv_* hold until the next accepted start. They may change while
//    busy; consumers sample them on done only.
//  - Upstream must hold cur_block and window contents stable while busy (no
//    regfile WE during search).
//  - |a-b| is computed on zero-extended 9-bit difference; no saturation is
//    needed because SAD_W is sufficient.
// STRUCTURE
//  - me_pkg: PIX_W, BLK, SW_DIM=22, NUM_POS=7, SAD_W, state encoding,
//    function code2disp(3b)->signed 3b (shared with window regfile mapping).
//  - Sub-module sad_col16: 16 pixel pairs -> 12-bit abs-diff sum, comb;
//    instantiated 16x for S1.
// TESTING
//  - cur_block equal to window at centre, other positions offset by +1 ->
//    best_sad=0, best_row=best_col=0, mv=(0,0), done at cycle 52.
//  - Unique match at R_ROW=3, R_COL=6 (others differ) -> best_sad=0,
//    best_row=3, best_col=6, mv_y=+3, mv_x=-3.
//  - Uniform window and block, all SADs equal to 256 -> best=(0,0) by tie rule,
//    best_sad=256.
//  - cur all 8'hFF, window all 8'h00 -> best_sad=65280, best=(0,0).
//  - start pulses during SCAN/DONE -> exactly one done per accepted start,
//    R_COL/R_ROW sequence unaffected.
//  - reset asserted in cycle 20 -> next edge: IDLE, outputs 0, no done.
//    A new start then gives a full 52-cycle run.

Source files
------------

// File: rtl/me_sad_search_pkg.sv
// Shared constants, state encoding and code-to-displacement mapping for the
// full-search SAD motion estimator.
package me_sad_search_pkg;

  localparam int PIX_W     = 8;
  localparam int BLK       = 16;
  localparam int SW_DIM    = 22;
  localparam int NUM_POS   = 7;
  localparam int SAD_W     = 16;
  localparam int COL_SAD_W = 12;
  localparam int POS_W     = 3;
  localparam int COL_W     = PIX_W * BLK;
  localparam int BLOCK_W   = COL_W * BLK;

  localparam logic [POS_W-1:0] LAST_CODE = POS_W'(NUM_POS - 1);
  localparam logic [SAD_W-1:0] SAD_INIT  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Position code 0..6 maps to displacement 0,+1,+2,+3,-1,-2,-3.
  function automatic logic signed [2:0] code2disp(input logic [2:0] code);
    logic signed [2:0] disp;
    case (code)
      3'd0:    disp = 3'sd0;
      3'd1:    disp = 3'sd1;
      3'd2:    disp = 3'sd2;
      3'd3:    disp = 3'sd3;
      3'd4:    disp = -3'sd1;
      3'd5:    disp = -3'sd2;
      3'd6:    disp = -3'sd3;
      default: disp = 3'sd0;
    endcase
    return disp;
  endfunction

endpackage

// File: rtl/me_sad_search_if.sv
// Block, window-port and result signals between the estimator and its
// neighbours (window regfile upstream, mode decision downstream).
interface me_sad_search_if;
  import me_sad_search_pkg::*;

  logic                    start;
  logic [BLOCK_W-1:0]      cur_block;
  logic [BLOCK_W-1:0]      cand_block;
  logic [POS_W-1:0]        R_ROW;
  logic [POS_W-1:0]        R_COL;
  logic                    busy;
  logic                    done;
  logic [SAD_W-1:0]        best_sad;
  logic [POS_W-1:0]        best_row;
  logic [POS_W-1:0]        best_col;
  logic signed [POS_W-1:0] mv_y;
  logic signed [POS_W-1:0] mv_x;

  modport master (
    output start, cur_block, cand_block,
    input  R_ROW, R_COL, busy, done, best_sad, best_row, best_col, mv_y, mv_x
  );

  modport slave (
    input  start, cur_block, cand_block,
    output R_ROW, R_COL, busy, done, best_sad, best_row, best_col, mv_y, mv_x
  );

endinterface

// File: rtl/me_sad_search_sad_col16.sv
// Sum of absolute differences over one 16-pixel block column.
module me_sad_search_sad_col16
  import me_sad_search_pkg::*;
(
  input  logic [COL_W-1:0]     cur_col,
  input  logic [COL_W-1:0]     cand_col,
  output logic [COL_SAD_W-1:0] sad
);

  logic [PIX_W:0]   diff;
  logic [PIX_W-1:0] abs_diff;

  // Accumulate |cur-cand| per row using a 9-bit zero-extended difference.
  always_comb begin
    sad      = '0;
    diff     = '0;
    abs_diff = '0;
    for (int r = 0; r < BLK; r++) begin
      diff     = {1'b0, cur_col[COL_W-1-r*PIX_W -: PIX_W]} -
                 {1'b0, cand_col[COL_W-1-r*PIX_W -: PIX_W]};
      abs_diff = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
      sad      = sad + COL_SAD_W'(abs_diff);
    end
  end

endmodule

// File: rtl/me_sad_search.sv
// Full-search integer motion estimator: walks all 7x7 window positions,
// computes a 16x16 SAD per position through a 3-stage pipeline and keeps the
// earliest minimum.
module me_sad_search
  import me_sad_search_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  me_sad_search_if.slave bus
);

  state_t               state_q;
  state_t               state_d;
  logic [POS_W-1:0]     row_q;
  logic [POS_W-1:0]     col_q;
  logic                 drain_q;
  logic                 accept;
  logic                 issue;
  logic                 last_pos;

  logic [COL_SAD_W-1:0] col_sad [BLK];
  logic [COL_SAD_W-1:0] s1_sad  [BLK];
  logic                 s1_valid;
  logic [POS_W-1:0]     s1_row;
  logic [POS_W-1:0]     s1_col;
  logic [SAD_W-1:0]     s1_sum;

  logic                 s2_valid;
  logic [SAD_W-1:0]     s2_sad;
  logic [POS_W-1:0]     s2_row;
  logic [POS_W-1:0]     s2_col;

  logic [SAD_W-1:0]     best_sad_q;
  logic [POS_W-1:0]     best_row_q;
  logic [POS_W-1:0]     best_col_q;

  assign last_pos = (row_q == LAST_CODE) && (col_q == LAST_CODE);

  for (genvar c = 0; c < BLK; c++) begin : g_col
    me_sad_search_sad_col16 u_col (
      .cur_col  (bus.cur_block[BLOCK_W-1-c*COL_W -: COL_W]),
      .cand_col (bus.cand_block[BLOCK_W-1-c*COL_W -: COL_W]),
      .sad      (col_sad[c])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus accept/issue strobes; start only counts in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        issue = 1'b1;
        if (last_pos) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Position codes (row inner, column outer) and the two-cycle drain timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
      if (issue) begin
        if (row_q == LAST_CODE) begin
          row_q <= '0;
          col_q <= (col_q == LAST_CODE) ? '0 : col_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

  // Pipeline valid bits, cleared on reset so a mid-scan reset drops in-flight SADs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= issue;
      s2_valid <= s1_valid;
    end
  end

  // Pipeline data: column SADs and codes at S1, summed SAD and codes at S2.
  always_ff @(posedge clk) begin
    for (int c = 0; c < BLK; c++) begin
      s1_sad[c] <= col_sad[c];
    end
    s1_row <= row_q;
    s1_col <= col_q;
    s2_sad <= s1_sum;
    s2_row <= s1_row;
    s2_col <= s1_col;
  end

  // Adder tree collapsing the 16 column SADs.
  always_comb begin
    s1_sum = '0;
    for (int c = 0; c < BLK; c++) begin
      s1_sum = s1_sum + SAD_W'(s1_sad[c]);
    end
  end

  // Best tracker: preset on accept, strict less-than keeps earliest minimum.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_sad_q <= '0;
      best_row_q <= '0;
      best_col_q <= '0;
    end else if (accept) begin
      best_sad_q <= SAD_INIT;
      best_row_q <= '0;
      best_col_q <= '0;
    end else if (s2_valid && (s2_sad < best_sad_q)) begin
      best_sad_q <= s2_sad;
      best_row_q <= s2_row;
      best_col_q <= s2_col;
    end
  end

  assign bus.R_ROW    = row_q;
  assign bus.R_COL    = col_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.best_sad = best_sad_q;
  assign bus.best_row = best_row_q;
  assign bus.best_col = best_col_q;
  assign bus.mv_y     = code2disp(best_row_q);
  assign bus.mv_x     = code2disp(best_col_q);

endmodule

// File: tb/tb_me_sad_search.sv
// Scoreboard bench for me_sad_search: a 22x22 window model feeds cand_block
// from R_ROW/R_COL, a direct full-search model predicts each result.
module tb_me_sad_search;

  localparam int SCAN_CYC = 49;
  localparam int DONE_OFS = 52;

  typedef struct packed {
    int start_cyc;
    int sad;
    int row;
    int col;
    int mvy;
    int mvx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  int   win [22][22];
  int   cur [16][16];
  int   disp_tab [8] = '{0, 1, 2, 3, -1, -2, -3, 0};
  exp_t exp_q [$];

  me_sad_search_if bus ();

  me_sad_search dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle index: during the interval after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2047:0] pack_cur();
    logic [2047:0] v;
    v = '0;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        v[2047-(c*128+r*8) -: 8] = 8'(cur[c][r]);
    return v;
  endfunction

  function automatic logic [2047:0] pack_cand(input int row_code, input int col_code);
    logic [2047:0] v;
    int dx;
    int dy;
    v  = '0;
    dx = disp_tab[col_code];
    dy = disp_tab[row_code];
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        v[2047-(c*128+r*8) -: 8] = 8'(win[3+dx+c][3+dy+r]);
    return v;
  endfunction

  // Window regfile model: DataOUT follows the position codes.
  always @(posedge clk) begin
    #1;
    bus.cand_block = pack_cand(int'(bus.R_ROW), int'(bus.R_COL));
  end

  function automatic exp_t ref_search();
    exp_t e;
    int   sad;
    int   a;
    int   b;
    e = '{start_cyc: 0, sad: 32'h7fffffff, row: 0, col: 0, mvy: 0, mvx: 0};
    for (int cc = 0; cc < 7; cc++) begin
      for (int rr = 0; rr < 7; rr++) begin
        sad = 0;
        for (int c = 0; c < 16; c++) begin
          for (int r = 0; r < 16; r++) begin
            a = cur[c][r];
            b = win[3+disp_tab[cc]+c][3+disp_tab[rr]+r];
            sad += (a > b) ? a - b : b - a;
          end
        end
        if (sad < e.sad) begin
          e.sad = sad;
          e.row = rr;
          e.col = cc;
          e.mvy = disp_tab[rr];
          e.mvx = disp_tab[cc];
        end
      end
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_busy"},     64'(bus.busy),     64'd0);
    check_output({tag, "_done"},     64'(bus.done),     64'd0);
    check_output({tag, "_R_ROW"},    64'(bus.R_ROW),    64'd0);
    check_output({tag, "_R_COL"},    64'(bus.R_COL),    64'd0);
    check_output({tag, "_best_sad"}, 64'(bus.best_sad), 64'd0);
    check_output({tag, "_best_row"}, 64'(bus.best_row), 64'd0);
    check_output({tag, "_best_col"}, 64'(bus.best_col), 64'd0);
    check_output({tag, "_mv_y"},     64'(bus.mv_y),     64'd0);
    check_output({tag, "_mv_x"},     64'(bus.mv_x),     64'd0);
  endtask

  // Monitor: checks scan order, busy, done timing and results against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check_output("idle_busy", 64'(bus.busy), 64'd0);
        check_output("idle_done", 64'(bus.done), 64'd0);
        check_output("idle_pos",  64'({bus.R_COL, bus.R_ROW}), 64'd0);
      end else begin
        exp_t e;
        e = exp_q[0];
        if (cyc <= e.start_cyc) begin
          check_output("pre_busy", 64'(bus.busy), 64'd0);
        end else begin
          check_output("run_busy", 64'(bus.busy), 64'd1);
          if (cyc <= e.start_cyc + SCAN_CYC) begin
            check_output("scan_R_COL", 64'(bus.R_COL), 64'((cyc - e.start_cyc - 1) / 7));
            check_output("scan_R_ROW", 64'(bus.R_ROW), 64'((cyc - e.start_cyc - 1) % 7));
          end
          if (cyc == e.start_cyc + DONE_OFS) begin
            check_output("done",     64'(bus.done),     64'd1);
            check_output("best_sad", 64'(bus.best_sad), 64'(e.sad));
            check_output("best_row", 64'(bus.best_row), 64'(e.row));
            check_output("best_col", 64'(bus.best_col), 64'(e.col));
            check_output("mv_y",     64'(bus.mv_y),     64'(e.mvy));
            check_output("mv_x",     64'(bus.mv_x),     64'(e.mvx));
            void'(exp_q.pop_front());
          end else begin
            check_output("early_done", 64'(bus.done), 64'd0);
          end
        end
      end
    end
  end

  task automatic load_cur();
    bus.cur_block = pack_cur();
  endtask

  task automatic fill_window(input int lo, input int hi);
    for (int x = 0; x < 22; x++)
      for (int y = 0; y < 22; y++)
        win[x][y] = int'($urandom_range(hi, lo));
  endtask

  task automatic fill_cur(input int lo, input int hi);
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        cur[c][r] = int'($urandom_range(hi, lo));
  endtask

  task automatic cur_from_window(input int row_code, input int col_code);
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        cur[c][r] = win[3+disp_tab[col_code]+c][3+disp_tab[row_code]+r];
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic apply_stimulus(output int s);
    exp_t e;
    @(negedge clk);
    e           = ref_search();
    e.start_cyc = cyc;
    s           = cyc;
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_one();
    int s;
    load_cur();
    apply_stimulus(s);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   s;
    exp_t e;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.cand_block = '0;
    for (int x = 0; x < 22; x++)
      for (int y = 0; y < 22; y++)
        win[x][y] = 0;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 16; r++)
        cur[c][r] = 0;
    load_cur();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    $display("[TB] centre match");
    fill_window(0, 255);
    cur_from_window(0, 0);
    run_one();

    $display("[TB] unique match at row 3, col 6");
    fill_window(0, 255);
    cur_from_window(3, 6);
    run_one();

    $display("[TB] uniform tie, SAD 256 everywhere");
    fill_window(8'h40, 8'h40);
    fill_cur(8'h41, 8'h41);
    run_one();

    $display("[TB] maximum SAD");
    fill_window(0, 0);
    fill_cur(255, 255);
    run_one();

    $display("[TB] random data");
    for (int i = 0; i < 3; i++) begin
      fill_window(0, 255);
      fill_cur(0, 255);
      run_one();
    end

    $display("[TB] low-entropy data with many ties");
    fill_window(0, 1);
    fill_cur(0, 1);
    run_one();

    $display("[TB] start pulses while busy, held start across done");
    fill_window(0, 255);
    cur_from_window(int'($urandom_range(6, 0)), int'($urandom_range(6, 0)));
    load_cur();
    apply_stimulus(s);
    wait_to(s + 10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(s + 30);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(s + 50);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(s + DONE_OFS);
    e           = ref_search();
    e.start_cyc = s + DONE_OFS + 1;
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    $display("[TB] reset in scan cycle 20");
    fill_window(0, 255);
    fill_cur(0, 255);
    load_cur();
    apply_stimulus(s);
    wait_to(s + 20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_cleared("midreset");
    reset = 1'b0;
    repeat (60) @(negedge clk);
    run_one();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
